ysyx_22040386_dmem_resp: RTL

YSYX_22040386_DMEM_RESP -- requirements
Module: ysyx_22040386_dmem_resp

---
 rtl/ysyx_22040386_dmem_pkg.sv | 25 ++
 rtl/ysyx_22040386_dmem_sram.sv | 31 +++
 rtl/ysyx_22040386_dmem.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ysyx_22040386_dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, response codes
// and the address-window test used to flag out-of-range accesses.
package ysyx_22040386_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  // Wide enough for LATENCY-1 with LATENCY up to 7.
  localparam int CNT_W = 3;

  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/ysyx_22040386_dmem_sram.sv
// Doubleword store built from eight byte lanes: synchronous per-byte write,
// combinational read at the same address.
module ysyx_22040386_dmem_sram
  import ysyx_22040386_dmem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [63:0]              wdata,
  input  logic [7:0]               wmask,
  output logic [63:0]              rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we && wmask[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/ysyx_22040386_dmem.sv
// Single-outstanding data-memory responder with a fixed response latency.
module ysyx_22040386_dmem_resp
  import ysyx_22040386_dmem_pkg::*;
#(
  parameter int          DEPTH   = 512,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        i_DMEM_clk,
  input  logic        i_DMEM_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [63:0]      SPAN     = 64'(DEPTH) << 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             wen_reg;
  logic [63:0]      addr_reg;
  logic [63:0]      wdata_reg;
  logic [7:0]       wmask_reg;

  logic        accept;
  logic        commit;
  logic        use_in;
  logic        cur_wen;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_wmask;
  logic        cur_in_range;
  logic [AW-1:0] sram_addr;
  logic        sram_we;
  logic [63:0] sram_rdata;
  logic [63:0] resp_rdata;
  logic        resp_err;

  assign accept = i_req_valid & o_req_ready;

  // With LATENCY=1 the access happens on the accept edge, so the live request
  // drives the array; otherwise the latched copy does.
  assign use_in    = (state_reg == ST_IDLE);
  assign cur_wen   = use_in ? i_req_wen   : wen_reg;
  assign cur_addr  = use_in ? i_req_addr  : addr_reg;
  assign cur_wdata = use_in ? i_req_wdata : wdata_reg;
  assign cur_wmask = use_in ? i_req_wmask : wmask_reg;

  assign cur_in_range = in_window(cur_addr, BASE, SPAN);
  assign sram_addr    = AW'((cur_addr - BASE) >> 3);

  assign commit  = ((state_reg == ST_WAIT) && (cnt_reg == '0)) ||
                   ((LATENCY == 1) && accept);
  assign sram_we = commit & cur_wen & cur_in_range;

  assign resp_rdata = (cur_in_range && !cur_wen) ? sram_rdata : 64'd0;
  assign resp_err   = cur_in_range ? RSP_OK : RSP_ERR;

  ysyx_22040386_dmem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (i_DMEM_clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (cur_wdata),
    .wmask (cur_wmask),
    .rdata (sram_rdata)
  );

  always_ff @(posedge i_DMEM_clk or negedge i_DMEM_rst_n) begin
    if (!i_DMEM_rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 64'd0;
      o_rsp_err   <= 1'b0;
      wen_reg     <= 1'b0;
      addr_reg    <= 64'd0;
      wdata_reg   <= 64'd0;
      wmask_reg   <= 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            wen_reg     <= i_req_wen;
            addr_reg    <= i_req_addr;
            wdata_reg   <= i_req_wdata;
            wmask_reg   <= i_req_wmask;
            cnt_reg     <= CNT_LOAD;
            o_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state_reg   <= ST_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= resp_rdata;
              o_rsp_err   <= resp_err;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg   <= ST_RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= resp_rdata;
            o_rsp_err   <= resp_err;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state_reg   <= ST_IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 64'd0;
            o_rsp_err   <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
